// File: rtl/alu_seq_responder_pkg.sv
// Shared types and sizing for the handshaked sequential ALU responder.
package alu_pkg;
    localparam int DATA_W    = 16;
    localparam int OP_W      = 4;
    localparam int MUL_ITERS = DATA_W;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT,
        ALU_SHL, ALU_SHR, ALU_ROL, ALU_ROR, ALU_EQ, ALU_LTU
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} alu_state_e;
endpackage

// File: rtl/alu_seq_responder_if.sv
// Request/response handshake bundle between the issuer and the ALU responder.
interface alu_seq_responder_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SEL_W-1:0] ALU_Sel;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] ALU_Out;
    logic             CarryOut;

    modport master (
        output req_valid, A, B, ALU_Sel, resp_ready,
        input  req_ready, resp_valid, ALU_Out, CarryOut
    );
    modport slave (
        input  req_valid, A, B, ALU_Sel, resp_ready,
        output req_ready, resp_valid, ALU_Out, CarryOut
    );
endinterface

// File: rtl/alu_seq_responder_mul.sv
// Iterative shift-add multiplier: one partial product per clock, ITERS clocks per product.
module alu_iter_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int ITERS = MUL_ITERS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int CNT_W = $clog2(ITERS + 1);

    logic [2*WIDTH-1:0] mcand_q, acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else if (busy_q) begin
            // Multiplier LSB selects whether the shifted multiplicand joins the sum.
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITERS - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = acc_q;
endmodule

// File: rtl/alu_seq_responder.sv
// Handshaked registered ALU: one request in flight, single-cycle ops plus iterative multiply.
module alu_seq_responder
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SEL_W = OP_W
) (
    input  logic               clk,
    input  logic               reset,
    alu_seq_responder_if.slave bus
);
    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, out_q, out_d;
    logic [SEL_W-1:0]   sel_q;
    logic               c_q, c_d;
    logic               accept, is_mul_req, mul_busy, mul_done;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     add_x, shl_x, shr_x;

    assign accept         = bus.req_valid && (state_q == IDLE);
    assign is_mul_req     = (bus.ALU_Sel == SEL_W'(ALU_MUL));
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.ALU_Out    = out_q;
    assign bus.CarryOut   = c_q;

    alu_iter_mul #(.WIDTH(WIDTH), .ITERS(WIDTH)) u_mul (
        .clk      (clk),
        .reset    (reset),
        .start_i  (accept && is_mul_req),
        .a_i      (bus.A),
        .b_i      (bus.B),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .product_o(prod)
    );

    // Shifts run one bit wider so the last bit shifted out lands in a fixed position.
    always_comb begin
        add_x = {1'b0, a_q} + {1'b0, b_q};
        shl_x = {1'b0, a_q} << b_q[3:0];
        shr_x = {a_q, 1'b0} >> b_q[3:0];
        out_d = a_q;
        c_d   = 1'b0;
        case (alu_op_e'(sel_q))
            ALU_ADD: {c_d, out_d} = add_x;
            ALU_SUB: begin out_d = a_q - b_q; c_d = (a_q < b_q); end
            ALU_AND: out_d = a_q & b_q;
            ALU_OR:  out_d = a_q | b_q;
            ALU_XOR: out_d = a_q ^ b_q;
            ALU_NOT: out_d = ~a_q;
            ALU_SHL: {c_d, out_d} = shl_x;
            ALU_SHR: begin out_d = shr_x[WIDTH:1]; c_d = shr_x[0]; end
            ALU_ROL: begin out_d = {a_q[WIDTH-2:0], a_q[WIDTH-1]}; c_d = a_q[WIDTH-1]; end
            ALU_ROR: begin out_d = {a_q[0], a_q[WIDTH-1:1]}; c_d = a_q[0]; end
            ALU_EQ:  out_d = WIDTH'(a_q == b_q);
            ALU_LTU: out_d = WIDTH'(a_q < b_q);
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = is_mul_req ? MUL : EXEC;
            EXEC:    state_d = DONE;
            MUL:     if (mul_done && !mul_busy) state_d = DONE;
            DONE:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            out_q   <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= bus.A;
                b_q   <= bus.B;
                sel_q <= bus.ALU_Sel;
            end
            if (state_q == EXEC) begin
                out_q <= out_d;
                c_q   <= c_d;
            end else if (state_q == MUL && mul_done) begin
                out_q <= prod[WIDTH-1:0];
                c_q   <= |prod[2*WIDTH-1:WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_responder.sv
// Directed bench for alu_seq_responder with a cycle-level reference model and per-cycle compare.
module tb_alu_seq_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_seq_responder_if #(.WIDTH(16), .SEL_W(4)) bus ();

    alu_seq_responder #(.WIDTH(16), .SEL_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the opcode table, in wide integers.
    function automatic void model(input int sel, input longint a, input longint b,
                                  output longint r, output bit c);
        int n;
        n = int'(b & 15);
        c = 1'b0;
        case (sel)
            0:  begin r = a + b; c = (r > 65535); end
            1:  begin r = a - b; c = (a < b); end
            2:  begin r = a * b; c = ((r >> 16) != 0); end
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = ~a;
            7:  begin r = a << n; c = (n != 0) && (((r >> 16) & 1) != 0); end
            8:  begin r = a >> n; c = (n != 0) && (((a >> (n - 1)) & 1) != 0); end
            9:  begin r = (a << 1) | (a >> 15); c = ((a >> 15) & 1) != 0; end
            10: begin r = (a >> 1) | ((a & 1) << 15); c = (a & 1) != 0; end
            11: r = (a == b) ? 1 : 0;
            12: r = (a < b) ? 1 : 0;
            default: r = a;
        endcase
        r = r & 65535;
    endfunction

    // Model: accept while idle, result visible lat edges later, retire on resp_ready.
    int          cyc = 0;
    int          m_done = 0;
    bit          m_busy = 1'b0;
    logic [15:0] m_out = '0;
    logic        m_c = 1'b0;

    always @(posedge clk or posedge reset) begin : mdl
        longint r;
        bit     c;
        if (reset) begin
            m_busy <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (!m_busy) begin
                if (bus.req_valid) begin
                    model(int'(bus.ALU_Sel), longint'(bus.A), longint'(bus.B), r, c);
                    m_busy <= 1'b1;
                    m_done <= cyc + 1 + ((bus.ALU_Sel == 4'd2) ? 17 : 1);
                    m_out  <= r[15:0];
                    m_c    <= c;
                end
            end else if (cyc >= m_done && bus.resp_ready) begin
                m_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_out", bus.ALU_Out, 0);
            chk("rst_carry", bus.CarryOut, 0);
            chk("rst_resp_valid", bus.resp_valid, 0);
            chk("rst_req_ready", bus.req_ready, 1);
        end else begin
            chk("mdl_resp_valid", bus.resp_valid, (m_busy && cyc >= m_done) ? 1 : 0);
            chk("mdl_req_ready", bus.req_ready, m_busy ? 0 : 1);
            if (m_busy && cyc >= m_done) begin
                chk("mdl_out", bus.ALU_Out, m_out);
                chk("mdl_carry", bus.CarryOut, m_c);
            end
        end
    end

    // Issue one op from idle (called #1 after a rising edge); elat is the sampling edge offset.
    task automatic do_op(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eo, input logic ec, input int elat);
        int k;
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.ALU_Sel = sel;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.A = 16'hDEAD;
        bus.B = 16'hBEEF;
        bus.ALU_Sel = 4'hF;
        k = 0;
        while (!bus.resp_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("resp_valid_wait", bus.resp_valid, 1);
        chk("latency", k + 1, elat);
        chk("lit_out", bus.ALU_Out, eo);
        chk("lit_carry", bus.CarryOut, ec);
        if (bus.resp_ready) begin
            @(posedge clk); #1;
            chk("consumed_rv", bus.resp_valid, 0);
            chk("consumed_rr", bus.req_ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        bus.ALU_Sel    = '0;
        bus.resp_ready = 1'b1;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        do_op(4'd0, 16'h00FA, 16'h0002, 16'h00FC, 1'b0, 2);
        do_op(4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 2);
        do_op(4'd1, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 2);
        do_op(4'd2, 16'h0100, 16'h0100, 16'h0000, 1'b1, 18);
        do_op(4'd2, 16'h00FA, 16'h0002, 16'h01F4, 1'b0, 18);
        do_op(4'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 18);
        do_op(4'd7, 16'h8001, 16'h0001, 16'h0002, 1'b1, 2);
        do_op(4'd8, 16'h0003, 16'h0000, 16'h0003, 1'b0, 2);
        do_op(4'd8, 16'h0003, 16'h0001, 16'h0001, 1'b1, 2);
        do_op(4'd7, 16'h1234, 16'h0010, 16'h1234, 1'b0, 2);
        do_op(4'd3, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 2);
        do_op(4'd4, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 2);
        do_op(4'd5, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 2);
        do_op(4'd6, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 2);
        do_op(4'd9, 16'h8001, 16'h0000, 16'h0003, 1'b1, 2);
        do_op(4'd10, 16'h0001, 16'h0000, 16'h8000, 1'b1, 2);
        do_op(4'd11, 16'h1234, 16'h1234, 16'h0001, 1'b0, 2);
        do_op(4'd12, 16'h0001, 16'h0002, 16'h0001, 1'b0, 2);
        do_op(4'd12, 16'h8000, 16'h0001, 16'h0000, 1'b0, 2);
        do_op(4'd13, 16'hABCD, 16'h1111, 16'hABCD, 1'b0, 2);

        // Backpressure: response held, a stray request while busy is dropped.
        bus.resp_ready = 1'b0;
        do_op(4'd0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.req_valid = 1'b1;
                bus.A = 16'h0001;
                bus.B = 16'h0001;
                bus.ALU_Sel = 4'd0;
            end
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            chk("bp_out", bus.ALU_Out, 16'h3333);
            chk("bp_carry", bus.CarryOut, 0);
            chk("bp_rv", bus.resp_valid, 1);
            chk("bp_rr", bus.req_ready, 0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_rv", bus.resp_valid, 0);
        chk("bp_release_rr", bus.req_ready, 1);
        @(posedge clk); #1;
        chk("bp_no_ghost", bus.resp_valid, 0);

        // Reset during the 8th multiply iteration.
        do_op(4'd0, 16'h00FA, 16'h0002, 16'h00FC, 1'b0, 2);
        bus.req_valid = 1'b1;
        bus.A = 16'h0100;
        bus.B = 16'h0003;
        bus.ALU_Sel = 4'd2;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_out", bus.ALU_Out, 0);
        chk("midrst_rv", bus.resp_valid, 0);
        chk("midrst_rr", bus.req_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("postrst_rr", bus.req_ready, 1);
        do_op(4'd0, 16'h1234, 16'h0101, 16'h1335, 1'b0, 2);
        repeat (25) @(posedge clk);
        #1 chk("postrst_idle_rv", bus.resp_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
